// File: rtl/intersection_phase_sequencer.sv
// ============================================================================
// intersection_phase_sequencer
//
// Purpose:
//   Phase controller for a four-signal intersection. It gives the up/down
//   through lanes green by default. It serves latched turn-lane and
//   pedestrian requests in turn-first order. Each phase is timed by a
//   down-counter, and an all-red clearance phase separates every pair of
//   green phases.
//
// Parameters:
//   GREEN_TIME  cycles spent in each green phase (UD, UT, PED), >= 1
//   CLEAR_TIME  cycles spent in each all-red clearance phase, >= 1
//
// Ports:
//   clock              in   1   single clock, all state updates on posedge
//   reset              in   1   synchronous, active-high
//   pedestrian_button  in   1   pedestrian request, level or pulse
//   turn_sensor        in   1   turn-lane request, level or pulse
//   pedestrian_green   out  1   pedestrian walk
//   up_green           out  1   up through-lane green
//   down_green         out  1   down through-lane green
//   turn_green         out  1   turn-lane green (conflicts with down)
//   state              out  8   current phase encoding
//   counter            out  32  cycles remaining in phase minus one
// ============================================================================
module intersection_phase_sequencer #(
    parameter int GREEN_TIME = 5,
    parameter int CLEAR_TIME = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pedestrian_button,
    input  logic        turn_sensor,
    output logic        pedestrian_green,
    output logic        up_green,
    output logic        down_green,
    output logic        turn_green,
    output logic [7:0]  state,
    output logic [31:0] counter
);

    // The worst-case round (UD -> UT -> PED -> UD) must fit inside the
    // 25-cycle liveness window that the interface checkers enforce.
    generate
        if (GREEN_TIME < 1 || CLEAR_TIME < 1 ||
            (2 * GREEN_TIME + 3 * CLEAR_TIME) > 24) begin : g_badParams
            $error("intersection_phase_sequencer: illegal GREEN_TIME/CLEAR_TIME");
        end
    endgenerate

    localparam logic [31:0] GREEN_LOAD = 32'(GREEN_TIME - 1);
    localparam logic [31:0] CLEAR_LOAD = 32'(CLEAR_TIME - 1);

    typedef enum logic [7:0] {
        UD      = 8'd0,
        UT      = 8'd1,
        PED     = 8'd2,
        CLR_UD  = 8'd3,
        CLR_UT  = 8'd4,
        CLR_PED = 8'd5
    } phase_e;

    phase_e      r_state;
    phase_e      w_nextState;
    logic [31:0] r_counter;
    logic [31:0] w_nextCounter;
    logic        r_turnReq;
    logic        r_pedReq;
    logic        w_turnPending;
    logic        w_pedPending;
    logic        w_phaseDone;

    // A live request on the input counts the same as a latched one, so a
    // pulse that lands exactly on a decision cycle is not lost.
    assign w_turnPending = r_turnReq | turn_sensor;
    assign w_pedPending  = r_pedReq | pedestrian_button;
    assign w_phaseDone   = (r_counter == 32'd0);

    // State register, phase counter and request latches. A request is
    // dropped on any cycle where its own phase is green, because that
    // phase is serving it right now.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= UD;
            r_counter <= GREEN_LOAD;
            r_turnReq <= 1'b0;
            r_pedReq  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_counter <= w_nextCounter;
            r_turnReq <= w_turnPending & (r_state != UT);
            r_pedReq  <= w_pedPending & (r_state != PED);
        end
    end

    // Next-state logic. The counter only decides a transition when it
    // reaches zero. Every transition, including UD re-entering itself,
    // reloads the duration of the phase being entered. An illegal
    // encoding recovers to UD at once, whatever the counter holds.
    always_comb begin
        w_nextState   = r_state;
        w_nextCounter = r_counter - 32'd1;
        case (r_state)
            UD: begin
                if (w_phaseDone) begin
                    if (w_turnPending | w_pedPending) begin
                        w_nextState   = CLR_UD;
                        w_nextCounter = CLEAR_LOAD;
                    end else begin
                        w_nextState   = UD;
                        w_nextCounter = GREEN_LOAD;
                    end
                end
            end
            CLR_UD: begin
                if (w_phaseDone) begin
                    w_nextCounter = GREEN_LOAD;
                    if (w_turnPending) begin
                        w_nextState = UT;
                    end else if (w_pedPending) begin
                        w_nextState = PED;
                    end else begin
                        w_nextState = UD;
                    end
                end
            end
            UT: begin
                if (w_phaseDone) begin
                    w_nextState   = CLR_UT;
                    w_nextCounter = CLEAR_LOAD;
                end
            end
            CLR_UT: begin
                if (w_phaseDone) begin
                    w_nextCounter = GREEN_LOAD;
                    w_nextState   = w_pedPending ? PED : UD;
                end
            end
            PED: begin
                if (w_phaseDone) begin
                    w_nextState   = CLR_PED;
                    w_nextCounter = CLEAR_LOAD;
                end
            end
            CLR_PED: begin
                if (w_phaseDone) begin
                    w_nextState   = UD;
                    w_nextCounter = GREEN_LOAD;
                end
            end
            default: begin
                w_nextState   = UD;
                w_nextCounter = GREEN_LOAD;
            end
        endcase
    end

    // Moore output decode. The outputs depend only on the state register,
    // so no request input can glitch a green. Clearance phases and
    // illegal encodings show all red.
    always_comb begin
        pedestrian_green = 1'b0;
        up_green         = 1'b0;
        down_green       = 1'b0;
        turn_green       = 1'b0;
        case (r_state)
            UD: begin
                up_green   = 1'b1;
                down_green = 1'b1;
            end
            UT: begin
                up_green   = 1'b1;
                turn_green = 1'b1;
            end
            PED: begin
                pedestrian_green = 1'b1;
            end
            default: begin
                pedestrian_green = 1'b0;
            end
        endcase
    end

    assign state   = r_state;
    assign counter = r_counter;

endmodule
